// File: rtl/ysyx_22050133_pkg.sv
// Shared types for the IFU/LSU memory arbiter: widths, FSM states, owner encoding
// and the latched memory request payload.
package ysyx_22050133_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef logic owner_t;
  localparam owner_t OWN_IF = 1'b0;
  localparam owner_t OWN_LS = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_22050133_mem_arbiter_if.sv
// IFU, LSU and memory-side handshake bundle; master is the arbiter's view,
// slave is the view of the surrounding requesters and memory.
interface ysyx_22050133_mem_arbiter_if
  import ysyx_22050133_pkg::*;
  ;

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req_valid;
  logic              ls_req_ready;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_wen;
  logic [DATA_W-1:0] ls_wdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              ls_resp_valid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_rdata,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/ysyx_22050133_rr_arb2.sv
// Two-way round-robin arbiter: req[0] = IF, req[1] = LS. A tie goes to the side
// that did not win last time; last_grant only moves when a grant is issued.
module ysyx_22050133_rr_arb2
  import ysyx_22050133_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output owner_t     last_grant_nx
);

  owner_t last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant == OWN_LS) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign last_grant_nx = grant[1] ? OWN_LS : (grant[0] ? OWN_IF : last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_LS;
    end else if (en && (|req)) begin
      last_grant <= last_grant_nx;
    end
  end

endmodule

// File: rtl/ysyx_22050133_mem_arbiter.sv
// Shares the single memory port between IFU and LSU: one transaction at a time,
// request held on the port until accepted, response routed back to its owner.
module ysyx_22050133_mem_arbiter
  import ysyx_22050133_pkg::*;
(
  input logic                         clk,
  input logic                         rst,
  ysyx_22050133_mem_arbiter_if.master bus
);

  arb_state_t        state;
  arb_state_t        state_nx;
  owner_t            owner;
  owner_t            last_grant_nx;
  logic [1:0]        grant;
  logic              arb_en;
  logic              resp_hit;
  mem_req_t          req_q;
  logic              if_resp_q;
  logic              ls_resp_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  // Gating with rst keeps the readys low while a synchronous reset is pending.
  assign arb_en   = (state == ARB_IDLE) && !rst;
  assign resp_hit = (state == ARB_RESP) && bus.mem_resp_valid;

  ysyx_22050133_rr_arb2 u_rr_arb2 (
    .clk           (clk),
    .rst           (rst),
    .en            (arb_en),
    .req           ({bus.ls_req_valid, bus.if_req_valid}),
    .grant         (grant),
    .last_grant_nx (last_grant_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE: if (|grant)              state_nx = ARB_REQ;
      ARB_REQ:  if (bus.mem_req_ready)   state_nx = ARB_RESP;
      ARB_RESP: if (bus.mem_resp_valid)  state_nx = ARB_IDLE;
      default:                           state_nx = ARB_IDLE;
    endcase
  end

  // Request capture on grant and response routing to the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= '0;
      owner      <= OWN_IF;
      if_resp_q  <= 1'b0;
      ls_resp_q  <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if_resp_q <= 1'b0;
      ls_resp_q <= 1'b0;
      if (grant[0]) begin
        req_q.addr  <= bus.if_addr;
        req_q.wen   <= 1'b0;
        req_q.wdata <= '0;
        req_q.wmask <= '0;
      end else if (grant[1]) begin
        req_q.addr  <= bus.ls_addr;
        req_q.wen   <= bus.ls_wen;
        req_q.wdata <= bus.ls_wdata;
        req_q.wmask <= bus.ls_wmask;
      end
      if (|grant) begin
        owner <= last_grant_nx;
      end
      if (resp_hit) begin
        if (owner == OWN_IF) begin
          if_resp_q  <= 1'b1;
          if_rdata_q <= bus.mem_rdata;
        end else begin
          ls_resp_q <= 1'b1;
          if (!req_q.wen) begin
            ls_rdata_q <= bus.mem_rdata;
          end
        end
      end
    end
  end

  assign bus.if_req_ready  = grant[0];
  assign bus.ls_req_ready  = grant[1];
  assign bus.if_resp_valid = if_resp_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.ls_resp_valid = ls_resp_q;
  assign bus.ls_rdata      = ls_rdata_q;
  assign bus.mem_req_valid = (state == ARB_REQ);
  assign bus.mem_addr      = req_q.addr;
  assign bus.mem_wen       = req_q.wen;
  assign bus.mem_wdata     = req_q.wdata;
  assign bus.mem_wmask     = req_q.wmask;

endmodule

// File: tb/tb_ysyx_22050133_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_ysyx_22050133_mem_arbiter;
  import ysyx_22050133_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ysyx_22050133_mem_arbiter_if bus ();

  ysyx_22050133_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req_valid   = 1'b0;
    bus.if_addr        = '0;
    bus.ls_req_valid   = 1'b0;
    bus.ls_addr        = '0;
    bus.ls_wen         = 1'b0;
    bus.ls_wdata       = '0;
    bus.ls_wmask       = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if ({bus.if_req_ready, bus.ls_req_ready, bus.if_resp_valid, bus.ls_resp_valid,
         bus.mem_req_valid, bus.mem_wen} !== 6'b0) begin
      bad++;
      $display("FAIL %s_ctrl got rdy=%b%b resp=%b%b mreq=%b wen=%b want all 0", name,
               bus.if_req_ready, bus.ls_req_ready, bus.if_resp_valid, bus.ls_resp_valid,
               bus.mem_req_valid, bus.mem_wen);
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== '0) begin
      bad++;
      $display("FAIL %s_mem got addr=%h wdata=%h wmask=%h want 0", name,
               bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
    end
    total++;
    if ({bus.if_rdata, bus.ls_rdata} !== '0) begin
      bad++;
      $display("FAIL %s_rdata got if=%h ls=%h want 0", name, bus.if_rdata, bus.ls_rdata);
    end
  endtask

  task automatic test_reset();
    do_reset();
    smp();
    check_reset_outputs("reset");
    cyc();
  endtask

  task automatic test_if_single();
    bus.if_req_valid  = 1'b1;
    bus.if_addr       = 64'h0000_0000_8000_0000;
    bus.mem_req_ready = 1'b1;
    smp();
    total++;
    if (bus.if_req_ready !== 1'b1) begin
      bad++; $display("FAIL if_single_ready got %b want 1", bus.if_req_ready);
    end
    cyc();
    bus.if_req_valid = 1'b0;
    bus.if_addr      = 64'hFFFF_FFFF_FFFF_FFFF;
    smp();
    total++;
    if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask} !==
        {1'b1, 64'h0000_0000_8000_0000, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL if_single_mem got v=%b addr=%h wen=%b wmask=%h want v=1 addr=80000000 wen=0 wmask=00",
               bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask);
    end
    cyc();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h0000_0013_0010_0093;
    smp();
    total++;
    if (bus.if_resp_valid !== 1'b0) begin
      bad++; $display("FAIL if_single_early got if_resp_valid=%b want 0", bus.if_resp_valid);
    end
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    smp();
    total++;
    if ({bus.if_resp_valid, bus.ls_resp_valid, bus.if_rdata} !==
        {1'b1, 1'b0, 64'h0000_0013_0010_0093}) begin
      bad++;
      $display("FAIL if_single_resp got if_v=%b ls_v=%b rdata=%h want 1 0 0000001300100093",
               bus.if_resp_valid, bus.ls_resp_valid, bus.if_rdata);
    end
    cyc();
    smp();
    total++;
    if (bus.if_resp_valid !== 1'b0) begin
      bad++; $display("FAIL if_single_pulse got if_resp_valid=%b want 0", bus.if_resp_valid);
    end
    cyc();
  endtask

  task automatic test_tie();
    bit want_if;
    do_reset();
    bus.if_req_valid  = 1'b1;
    bus.if_addr       = 64'h1000;
    bus.ls_req_valid  = 1'b1;
    bus.ls_addr       = 64'h2000;
    bus.ls_wen        = 1'b0;
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      want_if = (i % 2 == 0);
      bus.mem_resp_valid = 1'b0;
      smp();
      total++;
      if ({bus.if_req_ready, bus.ls_req_ready} !== {want_if, !want_if}) begin
        bad++;
        $display("FAIL tie_grant i=%0d got if=%b ls=%b want if=%b ls=%b", i,
                 bus.if_req_ready, bus.ls_req_ready, want_if, !want_if);
      end
      if (i > 0) begin
        total++;
        if ({bus.if_resp_valid, bus.ls_resp_valid} !== {!want_if, want_if}) begin
          bad++;
          $display("FAIL tie_resp i=%0d got if=%b ls=%b want if=%b ls=%b", i,
                   bus.if_resp_valid, bus.ls_resp_valid, !want_if, want_if);
        end
      end
      cyc();
      smp();
      total++;
      if ({bus.if_req_ready, bus.ls_req_ready, bus.mem_addr} !==
          {2'b00, want_if ? 64'h1000 : 64'h2000}) begin
        bad++;
        $display("FAIL tie_req i=%0d got rdy=%b%b addr=%h want rdy=00 addr=%h", i,
                 bus.if_req_ready, bus.ls_req_ready, bus.mem_addr,
                 want_if ? 64'h1000 : 64'h2000);
      end
      cyc();
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 64'h100 + 64'(i);
      smp();
      cyc();
    end
    idle_inputs();
    smp();
    total++;
    if ({bus.if_resp_valid, bus.ls_resp_valid, bus.if_rdata, bus.ls_rdata} !==
        {1'b0, 1'b1, 64'h102, 64'h103}) begin
      bad++;
      $display("FAIL tie_final got if_v=%b ls_v=%b if=%h ls=%h want 0 1 102 103",
               bus.if_resp_valid, bus.ls_resp_valid, bus.if_rdata, bus.ls_rdata);
    end
    cyc();
  endtask

  task automatic test_ls_write_stall();
    logic [136:0] want;
    want = {64'h0000_0000_8000_1000, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F};
    bus.ls_req_valid  = 1'b1;
    bus.ls_addr       = 64'h0000_0000_8000_1000;
    bus.ls_wen        = 1'b1;
    bus.ls_wdata      = 64'hDEAD_BEEF_CAFE_F00D;
    bus.ls_wmask      = 8'h0F;
    bus.mem_req_ready = 1'b0;
    smp();
    total++;
    if (bus.ls_req_ready !== 1'b1) begin
      bad++; $display("FAIL wr_ready got %b want 1", bus.ls_req_ready);
    end
    cyc();
    bus.ls_req_valid = 1'b0;
    bus.ls_addr      = {$urandom, $urandom};
    bus.ls_wen       = 1'b0;
    bus.ls_wdata     = {$urandom, $urandom};
    bus.ls_wmask     = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      bus.mem_req_ready = (i == 5);
      smp();
      total++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !==
          {1'b1, want}) begin
        bad++;
        $display("FAIL wr_stall c=%0d got v=%b %h %b %h %h want 1 %h", i, bus.mem_req_valid,
                 bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask, want);
      end
      cyc();
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h5555_AAAA_5555_AAAA;
    smp();
    total++;
    if (bus.ls_resp_valid !== 1'b0) begin
      bad++; $display("FAIL wr_early got ls_resp_valid=%b want 0", bus.ls_resp_valid);
    end
    cyc();
    bus.mem_resp_valid = 1'b0;
    smp();
    total++;
    if ({bus.ls_resp_valid, bus.ls_rdata} !== {1'b1, 64'h103}) begin
      bad++;
      $display("FAIL wr_resp got v=%b rdata=%h want 1 103", bus.ls_resp_valid, bus.ls_rdata);
    end
    cyc();
    smp();
    total++;
    if (bus.ls_resp_valid !== 1'b0) begin
      bad++; $display("FAIL wr_pulse got %b want 0", bus.ls_resp_valid);
    end
    cyc();
  endtask

  task automatic test_spurious();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h0BAD_0BAD_0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      cyc();
      smp();
      total++;
      if ({bus.if_resp_valid, bus.ls_resp_valid, bus.mem_req_valid} !== 3'b000) begin
        bad++;
        $display("FAIL spur_idle got resp=%b%b mreq=%b want 000",
                 bus.if_resp_valid, bus.ls_resp_valid, bus.mem_req_valid);
      end
    end
    cyc();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 64'h44;
    smp();
    total++;
    if (bus.if_req_ready !== 1'b1) begin
      bad++; $display("FAIL spur_idle_grant got if_req_ready=%b want 1", bus.if_req_ready);
    end
    cyc();
    bus.if_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      total++;
      if ({bus.mem_req_valid, bus.if_resp_valid, bus.ls_resp_valid} !== 3'b100) begin
        bad++;
        $display("FAIL spur_req c=%0d got mreq=%b resp=%b%b want 100", i,
                 bus.mem_req_valid, bus.if_resp_valid, bus.ls_resp_valid);
      end
      cyc();
    end
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    cyc();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h7777;
    cyc();
    bus.mem_resp_valid = 1'b0;
    smp();
    total++;
    if ({bus.if_resp_valid, bus.if_rdata} !== {1'b1, 64'h7777}) begin
      bad++;
      $display("FAIL spur_resp got v=%b rdata=%h want 1 7777", bus.if_resp_valid, bus.if_rdata);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    bus.ls_req_valid  = 1'b1;
    bus.ls_addr       = 64'h8000_2000;
    bus.ls_wen        = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.ls_req_valid = 1'b0;
    cyc();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'hFEED;
    smp();
    check_reset_outputs("rstmid");
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.if_req_valid   = 1'b1;
    bus.if_addr        = 64'h88;
    bus.ls_req_valid   = 1'b1;
    smp();
    total++;
    if ({bus.ls_resp_valid, bus.ls_rdata, bus.if_req_ready, bus.ls_req_ready} !==
        {1'b0, 64'h0, 2'b10}) begin
      bad++;
      $display("FAIL rstmid_after got ls_v=%b ls_rdata=%h rdy=%b%b want 0 0 10",
               bus.ls_resp_valid, bus.ls_rdata, bus.if_req_ready, bus.ls_req_ready);
    end
    cyc();
    idle_inputs();
    do_reset();
  endtask

  task automatic test_random();
    bit          ifp, lsp, g_if, g_ls, resp_drv, spur, rdy, want_if_p, want_ls_p;
    logic [63:0] if_a, ls_a, ls_d, m_if_rdata, m_ls_rdata, rd;
    logic        ls_w;
    logic [7:0]  ls_m;
    mem_req_t    exp_req;
    owner_t      own, last;
    int          phase, dly;
    do_reset();
    ifp = 0; lsp = 0; phase = 0; dly = 0; last = OWN_LS; own = OWN_IF;
    want_if_p = 0; want_ls_p = 0; m_if_rdata = '0; m_ls_rdata = '0;
    exp_req = '0; if_a = '0; ls_a = '0; ls_d = '0; ls_w = 0; ls_m = '0;
    for (int c = 0; c < 600; c++) begin
      bus.if_req_valid = ifp;
      bus.if_addr      = ifp ? if_a : {$urandom, $urandom};
      bus.ls_req_valid = lsp;
      bus.ls_addr      = lsp ? ls_a : {$urandom, $urandom};
      bus.ls_wen       = lsp ? ls_w : 1'($urandom);
      bus.ls_wdata     = lsp ? ls_d : {$urandom, $urandom};
      bus.ls_wmask     = lsp ? ls_m : 8'($urandom);
      rdy              = ($urandom_range(0, 2) != 0);
      bus.mem_req_ready = rdy;
      resp_drv = (phase == 2) && (dly == 0);
      spur     = (phase != 2) && ($urandom_range(0, 7) == 0);
      rd       = {$urandom, $urandom};
      bus.mem_resp_valid = resp_drv || spur;
      bus.mem_rdata      = rd;
      smp();
      g_if = (phase == 0) && ifp && (!lsp || last == OWN_LS);
      g_ls = (phase == 0) && lsp && !g_if;
      total++;
      if ({bus.if_req_ready, bus.ls_req_ready, bus.mem_req_valid} !== {g_if, g_ls, phase == 1}) begin
        bad++;
        $display("FAIL rnd_ctrl c=%0d got rdy=%b%b mreq=%b want %b%b %b", c, bus.if_req_ready,
                 bus.ls_req_ready, bus.mem_req_valid, g_if, g_ls, phase == 1);
      end
      total++;
      if ({bus.if_resp_valid, bus.ls_resp_valid, bus.if_rdata, bus.ls_rdata} !==
          {want_if_p, want_ls_p, m_if_rdata, m_ls_rdata}) begin
        bad++;
        $display("FAIL rnd_resp c=%0d got v=%b%b if=%h ls=%h want %b%b %h %h", c,
                 bus.if_resp_valid, bus.ls_resp_valid, bus.if_rdata, bus.ls_rdata,
                 want_if_p, want_ls_p, m_if_rdata, m_ls_rdata);
      end
      if (phase == 1) begin
        total++;
        if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !== exp_req) begin
          bad++;
          $display("FAIL rnd_mem c=%0d got %h %b %h %h want %h", c, bus.mem_addr, bus.mem_wen,
                   bus.mem_wdata, bus.mem_wmask, exp_req);
        end
      end
      want_if_p = 0;
      want_ls_p = 0;
      case (phase)
        0: begin
          if (g_if) begin
            exp_req = '{addr: if_a, wen: 1'b0, wdata: '0, wmask: '0};
            own = OWN_IF; last = OWN_IF; ifp = 0; phase = 1;
          end else if (g_ls) begin
            exp_req = '{addr: ls_a, wen: ls_w, wdata: ls_d, wmask: ls_m};
            own = OWN_LS; last = OWN_LS; lsp = 0; phase = 1;
          end
        end
        1: if (rdy) begin
          phase = 2;
          dly = int'($urandom_range(0, 3));
        end
        default: begin
          if (resp_drv) begin
            phase = 0;
            if (own == OWN_IF) begin
              want_if_p = 1; m_if_rdata = rd;
            end else begin
              want_ls_p = 1;
              if (!exp_req.wen) m_ls_rdata = rd;
            end
          end else begin
            dly--;
          end
        end
      endcase
      if (!ifp && $urandom_range(0, 3) == 0) begin
        ifp = 1; if_a = {$urandom, $urandom};
      end
      if (!lsp && $urandom_range(0, 3) == 0) begin
        lsp = 1; ls_a = {$urandom, $urandom}; ls_w = 1'($urandom);
        ls_d = {$urandom, $urandom}; ls_m = 8'($urandom);
      end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_if_single();
    test_tie();
    test_ls_write_stall();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish by 100000 want finish");
    $fatal(1, "timeout");
  end

endmodule
